// File: rtl/control_pkg.sv
// Shared opcodes, sequencer states and control-word bit indices for the Mini SRC control unit.
package control_pkg;

  localparam int OP_LDI      = 5'b00001;
  localparam int OP_ADD      = 5'b00011;
  localparam int OP_SUB      = 5'b00100;
  localparam int OP_SHR      = 5'b00101;
  localparam int OP_SHL      = 5'b00110;
  localparam int OP_ROR      = 5'b00111;
  localparam int OP_ROL      = 5'b01000;
  localparam int OP_AND      = 5'b01001;
  localparam int OP_OR       = 5'b01010;
  localparam int OP_ALU_LAST = 5'b01011;
  localparam int OP_BR       = 5'b10010;
  localparam int OP_JR       = 5'b10100;
  localparam int OP_JAL      = 5'b10101;
  localparam int OP_NOP      = 5'b11010;
  localparam int OP_HALT     = 5'b11011;

  // 3 bits already reach T6, so the BRANCH_EN build needs no wider counter
  localparam int STEP_W = 3;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH0,
    ST_FETCH1,
    ST_FETCH1_WAIT,
    ST_FETCH2,
    ST_EXEC,
    ST_HALTED
  } state_t;

  localparam int C_PCOUT    = 0;
  localparam int C_MARIN    = 1;
  localparam int C_INCPC    = 2;
  localparam int C_ZIN      = 3;
  localparam int C_ZLO_OUT  = 4;
  localparam int C_PCIN     = 5;
  localparam int C_MDRIN    = 6;
  localparam int C_MEM_READ = 7;
  localparam int C_MEM_EN   = 8;
  localparam int C_MDROUT   = 9;
  localparam int C_IRIN     = 10;
  localparam int C_GRA      = 11;
  localparam int C_GRB      = 12;
  localparam int C_GRC      = 13;
  localparam int C_ROUT     = 14;
  localparam int C_RIN      = 15;
  localparam int C_BAOUT    = 16;
  localparam int C_YIN      = 17;
  localparam int C_COUT     = 18;
  localparam int C_CONIN    = 19;
  localparam int CTRL_W     = 20;

endpackage

// File: rtl/control_decode.sv
// Combinational execute-step decoder: (opcode, step) -> control word, ALU op, last-step and illegal flags.
// BRANCH_EN adds the four-step br sequence; otherwise br decodes as illegal.
module control_decode
  import control_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] op,
  input  logic [STEP_W-1:0]   step,
  input  logic                con_ff_bit,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                last_step,
  output logic                illegal
);

  logic is_ldi;
  logic is_alu;

  assign is_ldi = (op == OPCODE_W'(OP_LDI));
  assign is_alu = (op >= OPCODE_W'(OP_ADD)) && (op <= OPCODE_W'(OP_ALU_LAST));

`ifndef BRANCH_EN
  logic unused_con;
  assign unused_con = con_ff_bit;
`endif

  always_comb begin
    ctrl      = '0;
    alu_op    = '0;
    last_step = 1'b1;
    illegal   = 1'b0;
    if (is_ldi || is_alu) begin
      // ldi reuses the R-type shape with BAout (r0 reads as 0) and C as operands
      case (step)
        STEP_W'(3): begin
          ctrl[C_GRB] = 1'b1;
          ctrl[C_YIN] = 1'b1;
          if (is_alu) ctrl[C_ROUT] = 1'b1;
          else        ctrl[C_BAOUT] = 1'b1;
          last_step = 1'b0;
        end
        STEP_W'(4): begin
          ctrl[C_ZIN] = 1'b1;
          if (is_alu) begin
            ctrl[C_GRC]  = 1'b1;
            ctrl[C_ROUT] = 1'b1;
            alu_op       = op;
          end else begin
            ctrl[C_COUT] = 1'b1;
            alu_op       = OPCODE_W'(OP_ADD);
          end
          last_step = 1'b0;
        end
        default: begin
          ctrl[C_ZLO_OUT] = 1'b1;
          ctrl[C_GRA]     = 1'b1;
          ctrl[C_RIN]     = 1'b1;
        end
      endcase
    end else if (op == OPCODE_W'(OP_JR)) begin
      ctrl[C_GRA]  = 1'b1;
      ctrl[C_ROUT] = 1'b1;
      ctrl[C_PCIN] = 1'b1;
    end else if (op == OPCODE_W'(OP_JAL)) begin
      if (step == STEP_W'(3)) begin
        ctrl[C_PCOUT] = 1'b1;
        ctrl[C_GRB]   = 1'b1;
        ctrl[C_RIN]   = 1'b1;
        last_step     = 1'b0;
      end else begin
        ctrl[C_GRA]  = 1'b1;
        ctrl[C_ROUT] = 1'b1;
        ctrl[C_PCIN] = 1'b1;
      end
`ifdef BRANCH_EN
    end else if (op == OPCODE_W'(OP_BR)) begin
      case (step)
        STEP_W'(3): begin
          ctrl[C_GRA]   = 1'b1;
          ctrl[C_ROUT]  = 1'b1;
          ctrl[C_CONIN] = 1'b1;
          last_step     = 1'b0;
        end
        STEP_W'(4): begin
          ctrl[C_PCOUT] = 1'b1;
          ctrl[C_YIN]   = 1'b1;
          last_step     = 1'b0;
        end
        STEP_W'(5): begin
          ctrl[C_COUT] = 1'b1;
          ctrl[C_ZIN]  = 1'b1;
          alu_op       = OPCODE_W'(OP_ADD);
          last_step    = 1'b0;
        end
        default: begin
          ctrl[C_ZLO_OUT] = 1'b1;
          ctrl[C_PCIN]    = con_ff_bit;
        end
      endcase
`endif
    end else if ((op != OPCODE_W'(OP_NOP)) && (op != OPCODE_W'(OP_HALT))) begin
      illegal = (step == STEP_W'(3));
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control sequencer: fetch T0-T2, decoded execute steps, stop/halt handling.
// Optional macro BRANCH_EN enables the br instruction (see control_decode).
//
// state          | meaning
// ST_RESET       | idle after clear, all strobes low
// ST_FETCH0      | T0: PC to MAR, increment PC
// ST_FETCH1      | T1 first cycle: PC update, start memory read
// ST_FETCH1_WAIT | T1 extra cycles holding the memory read
// ST_FETCH2      | T2: MDR to IR
// ST_EXEC        | T3.. execute steps from the decoder
// ST_HALTED      | stopped until clear
module control_sequencer
  import control_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int OPCODE_W        = 5,
  parameter int MEM_WAIT_CYCLES = 0
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic                  con_ff_bit,
  input  logic                  stop,
  output logic [CTRL_W-1:0]     ctrl,
  output logic [OPCODE_W-1:0]   opcode,
  output logic                  run,
  output logic                  illegal
);

  state_t            state, state_nxt;
  logic [STEP_W-1:0] step, step_nxt;
  logic [2:0]        wait_cnt, wait_cnt_nxt;

  logic [OPCODE_W-1:0] ir_op;
  logic [CTRL_W-1:0]   dec_ctrl;
  logic [OPCODE_W-1:0] dec_alu_op;
  logic                dec_last;
  logic                dec_illegal;
  logic                unused_ir;

  assign ir_op     = ir[DATA_WIDTH-1 -: OPCODE_W];
  assign unused_ir = ^ir[DATA_WIDTH-OPCODE_W-1:0];

  control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .op        (ir_op),
    .step      (step),
    .con_ff_bit(con_ff_bit),
    .ctrl      (dec_ctrl),
    .alu_op    (dec_alu_op),
    .last_step (dec_last),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge Clock) begin
    if (clear) begin
      state    <= ST_RESET;
      step     <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      step     <= step_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    step_nxt     = step;
    wait_cnt_nxt = wait_cnt;
    ctrl         = '0;
    opcode       = '0;
    illegal      = 1'b0;
    run          = (state != ST_RESET) && (state != ST_HALTED);
    case (state)
      ST_RESET: begin
        state_nxt = ST_FETCH0;
        step_nxt  = '0;
      end
      ST_FETCH0: begin
        ctrl[C_PCOUT] = 1'b1;
        ctrl[C_MARIN] = 1'b1;
        ctrl[C_INCPC] = 1'b1;
        ctrl[C_ZIN]   = 1'b1;
        state_nxt     = ST_FETCH1;
        step_nxt      = STEP_W'(1);
      end
      ST_FETCH1: begin
        ctrl[C_ZLO_OUT]  = 1'b1;
        ctrl[C_PCIN]     = 1'b1;
        ctrl[C_MDRIN]    = 1'b1;
        ctrl[C_MEM_READ] = 1'b1;
        ctrl[C_MEM_EN]   = 1'b1;
        if (MEM_WAIT_CYCLES == 0) begin
          state_nxt = ST_FETCH2;
          step_nxt  = STEP_W'(2);
        end else begin
          state_nxt    = ST_FETCH1_WAIT;
          wait_cnt_nxt = 3'(MEM_WAIT_CYCLES);
        end
      end
      ST_FETCH1_WAIT: begin
        ctrl[C_MDRIN]    = 1'b1;
        ctrl[C_MEM_READ] = 1'b1;
        ctrl[C_MEM_EN]   = 1'b1;
        wait_cnt_nxt     = wait_cnt - 3'd1;
        if (wait_cnt == 3'd1) begin
          state_nxt = ST_FETCH2;
          step_nxt  = STEP_W'(2);
        end
      end
      ST_FETCH2: begin
        ctrl[C_MDROUT] = 1'b1;
        ctrl[C_IRIN]   = 1'b1;
        // nop/halt are resolved here from the opcode presented on ir
        if (ir_op == OPCODE_W'(OP_HALT)) begin
          state_nxt = ST_HALTED;
          step_nxt  = '0;
        end else if (ir_op == OPCODE_W'(OP_NOP)) begin
          state_nxt = stop ? ST_HALTED : ST_FETCH0;
          step_nxt  = '0;
        end else begin
          state_nxt = ST_EXEC;
          step_nxt  = STEP_W'(3);
        end
      end
      ST_EXEC: begin
        ctrl    = dec_ctrl;
        opcode  = dec_alu_op;
        illegal = dec_illegal;
        if (dec_last) begin
          state_nxt = stop ? ST_HALTED : ST_FETCH0;
          step_nxt  = '0;
        end else begin
          step_nxt = step + STEP_W'(1);
        end
      end
      ST_HALTED: begin
        step_nxt = '0;
      end
      default: begin
        state_nxt = ST_RESET;
        step_nxt  = '0;
      end
    endcase
  end

endmodule
